// File: rtl/mem_responder.sv
// Byte-addressable memory slave with a single outstanding request and fixed response latency.
// Loads and stores are little-endian with sign/zero extension and alignment checking.
module mem_responder #(
    parameter int    ADDRESS_REAL_WIDTH = 16,
    parameter int    LATENCY            = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW    = ADDRESS_REAL_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [2:0]      mode_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q;
    logic            capture;
    logic            enter_resp;

    logic [7:0] mem [DEPTH];

    // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
    // operation must be taken straight from the request ports in IDLE.
    logic            cur_we;
    logic [2:0]      cur_mode;
    logic [AW-1:0]   a0, a1, a2, a3;
    logic [31:0]     cur_wdata;
    logic            cur_err;
    logic [7:0]      b0, b1, b2, b3;
    logic [31:0]     ld_data;

    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we              : we_q;
        cur_mode  = (state_q == IDLE) ? req_mode            : mode_q;
        a0        = (state_q == IDLE) ? req_addr[AW-1:0]    : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata           : wdata_q;
        a1        = a0 + AW'(1);
        a2        = a0 + AW'(2);
        a3        = a0 + AW'(3);
        cur_err   = (cur_mode[1:0] == 2'b11)
                  || ((cur_mode[1:0] == 2'b01) && a0[0])
                  || ((cur_mode[1:0] == 2'b10) && (a0[1:0] != 2'b00));
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        case (cur_mode[1:0])
            2'b00:   ld_data = {{24{b0[7] & ~cur_mode[2]}}, b0};
            2'b01:   ld_data = {{16{b1[7] & ~cur_mode[2]}}, b1, b0};
            default: ld_data = {b3, b2, b1, b0};
        endcase
        rdata_d = (cur_we || cur_err) ? 32'd0 : ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            mode_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= req_we;
                mode_q  <= req_mode;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= cur_err;
            end
        end
    end

    // Storage has no reset; rst gates the write so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && cur_we && !cur_err) begin
            mem[a0] <= cur_wdata[7:0];
            if (cur_mode[1:0] != 2'b00) mem[a1] <= cur_wdata[15:8];
            if (cur_mode[1:0] == 2'b10) begin
                mem[a2] <= cur_wdata[23:16];
                mem[a3] <= cur_wdata[31:24];
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'd0;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, backpressure and reset sequences,
// then random traffic checked against a byte-array memory model.
module tb_mem_responder;
    localparam int AW  = 16;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_mode = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    mem_responder #(.ADDRESS_REAL_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte unsigned mem_m [1 << AW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: applies the access to the model memory and returns the expected response.
    task automatic model(input bit we, input bit [2:0] mode, input bit [31:0] addr,
                         input bit [31:0] wdata, output bit [31:0] rd, output bit err);
        int size  = mode[1:0];
        int nbyte = 1 << size;
        int base  = addr % (1 << AW);
        longint val = 0;
        err = (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
        rd  = 0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nbyte; i++)
                mem_m[(base + i) % (1 << AW)] = byte'((wdata >> (8 * i)) & 32'hFF);
            return;
        end
        for (int i = 0; i < nbyte; i++)
            val += longint'(mem_m[(base + i) % (1 << AW)]) << (8 * i);
        if (size < 2 && !mode[2] && val >= (longint'(1) << (8 * nbyte - 1)))
            val -= longint'(1) << (8 * nbyte);
        rd = 32'(val);
    endtask

    // Called at a negedge; performs one full request/response and returns what the DUT gave.
    task automatic xact(input bit we, input bit [2:0] mode, input bit [31:0] addr,
                        input bit [31:0] wdata, output bit [31:0] rd, output bit err,
                        output int lat);
        int g = 0;
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
        while (!req_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 40);
        rd  = rsp_rdata;
        err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        bit        we;
        bit [2:0]  mode;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rd;
        bit        exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit [31:0] rd, mrd;
        bit        err, merr;
        int        lat;

        vecs[0]  = '{1, 3'b010, 32'h100,   32'hDEADBEEF, 32'h0,        0};
        vecs[1]  = '{0, 3'b010, 32'h100,   32'h0,        32'hDEADBEEF, 0};
        vecs[2]  = '{0, 3'b000, 32'h100,   32'h0,        32'hFFFFFFEF, 0};
        vecs[3]  = '{0, 3'b100, 32'h103,   32'h0,        32'h000000DE, 0};
        vecs[4]  = '{0, 3'b001, 32'h102,   32'h0,        32'hFFFFDEAD, 0};
        vecs[5]  = '{0, 3'b101, 32'h100,   32'h0,        32'h0000BEEF, 0};
        vecs[6]  = '{1, 3'b000, 32'h101,   32'hFFFFFF12, 32'h0,        0};
        vecs[7]  = '{0, 3'b010, 32'h100,   32'h0,        32'hDEAD12EF, 0};
        vecs[8]  = '{1, 3'b010, 32'h102,   32'h11111111, 32'h0,        1};
        vecs[9]  = '{0, 3'b010, 32'h100,   32'h0,        32'hDEAD12EF, 0};
        vecs[10] = '{0, 3'b001, 32'h101,   32'h0,        32'h0,        1};
        vecs[11] = '{1, 3'b010, 32'hFFFC,  32'hA5A55A5A, 32'h0,        0};
        vecs[12] = '{0, 3'b011, 32'h1FFFC, 32'h0,        32'h0,        1};

        // async reset, checked before any clock edge
        #2 rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].wdata, rd, err, lat);
            model(vecs[i].we, vecs[i].mode, vecs[i].addr, vecs[i].wdata, mrd, merr);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
        end
        // aliased word load from the top of storage
        xact(0, 3'b010, 32'hABCDFFFC, 0, rd, err, lat);
        chk("top_alias_rdata", rd, 32'hA5A55A5A);
        chk("top_alias_err", 32'(err), 32'd0);

        // backpressure with a competing request held on the port
        begin
            int g = 0;
            bit [31:0] held;
            req_valid = 1'b1; req_we = 1'b0; req_mode = 3'b010; req_addr = 32'h100;
            @(posedge clk); #1;
            req_mode = 3'b101;
            g = 0;
            do begin @(negedge clk); g++; end while (!rsp_valid && g < 40);
            chk("bp_first_valid", 32'(rsp_valid), 32'd1);
            held = rsp_rdata;
            chk("bp_first_rdata", held, 32'hDEAD12EF);
            repeat (5) begin
                @(posedge clk); @(negedge clk);
                chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("bp_hold_rdata", rsp_rdata, 32'hDEAD12EF);
                chk("bp_hold_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
            chk("bp_after_hs_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat = 0;
            do begin @(posedge clk); lat++; @(negedge clk); end while (!rsp_valid && lat < 40);
            chk("bp_second_lat", 32'(lat), 32'(LAT));
            chk("bp_second_rdata", rsp_rdata, 32'h000012EF);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            @(negedge clk);
        end

        // reset during WAIT aborts a store
        req_valid = 1'b1; req_we = 1'b1; req_mode = 3'b010;
        req_addr = 32'h200; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        xact(0, 3'b010, 32'h200, 0, rd, err, lat);
        model(0, 3'b010, 32'h200, 0, mrd, merr);
        chk("mid_rst_load", rd, mrd);
        chk("mid_rst_lat", 32'(lat), 32'(LAT));

        // random traffic
        for (int n = 0; n < 250; n++) begin
            bit        we   = 1'($urandom_range(0, 1));
            bit [2:0]  mode = 3'($urandom_range(0, 7));
            bit [31:0] addr;
            bit [31:0] wd   = $urandom;
            case ($urandom_range(0, 3))
                0:       addr = 32'hFFF8 + 32'($urandom_range(0, 7));
                1:       addr = ($urandom & 32'hFFFF0000) | (32'h300 + 32'($urandom_range(0, 31)));
                default: addr = 32'h300 + 32'($urandom_range(0, 31));
            endcase
            xact(we, mode, addr, wd, rd, err, lat);
            model(we, mode, addr, wd, mrd, merr);
            chk($sformatf("rnd%0d_rdata", n), rd, mrd);
            chk($sformatf("rnd%0d_err", n), 32'(err), 32'(merr));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(LAT));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
